// File: rtl/qam_tx_sequencer.sv
// 16-QAM TX frame sequencer: one symbol pull per SPS sample ticks, zero flush, output-valid delay line.
// Latency: first tick CLK_DIV cycles after start; out_valid trails sample_en by PIPE_LAT; no stall, misses flag underrun.
module qam_tx_sequencer #(
  parameter int SPS           = 8,
  parameter int FRAME_SYMS    = 1024,
  parameter int FLUSH_SAMPLES = 32,
  parameter int CLK_DIV       = 2,
  parameter int PIPE_LAT      = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic abort_i,
  input  logic bits_valid_i,
  output logic bits_ready_o,
  output logic sym_load_o,
  output logic sample_en_o,
  output logic zero_insert_o,
  output logic out_valid_o,
  output logic busy_o,
  output logic done_o,
  output logic underrun_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_W  = $clog2(SPS);
  localparam int SYM_W = $clog2(FRAME_SYMS + 1);
  localparam int FL_W  = $clog2(FLUSH_SAMPLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SPS - 1);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(FRAME_SYMS);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_SAMPLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [SYM_W-1:0]    sym_cnt_q, sym_cnt_d;
  logic [FL_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic                underrun_q, underrun_d;
  logic [PIPE_LAT-1:0] pipe_q, pipe_d;
  logic                tick, slot;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      phase_q     <= '0;
      sym_cnt_q   <= '0;
      flush_cnt_q <= '0;
      underrun_q  <= 1'b0;
      pipe_q      <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      phase_q     <= phase_d;
      sym_cnt_q   <= sym_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      underrun_q  <= underrun_d;
      pipe_q      <= pipe_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    phase_d       = phase_q;
    sym_cnt_d     = sym_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    underrun_d    = underrun_q;
    pipe_d        = '0;
    tick          = 1'b0;
    slot          = 1'b0;
    done_o        = 1'b0;
    bits_ready_o  = 1'b0;
    sym_load_o    = 1'b0;
    sample_en_o   = 1'b0;
    zero_insert_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        div_cnt_d   = '0;
        phase_d     = '0;
        sym_cnt_d   = '0;
        flush_cnt_d = '0;
        // underrun stays visible after a frame until the next one is launched
        if (start_i) begin
          underrun_d = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN, S_FLUSH: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          tick      = (div_cnt_q == DIV_LAST);
          div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
          if (tick && state_q == S_RUN) begin
            slot    = (phase_q == '0) && (sym_cnt_q < SYM_LAST);
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
            if (slot) sym_cnt_d = sym_cnt_q + 1'b1;
            // a missed slot still consumes its symbol period to keep frame timing
            if (slot && !bits_valid_i) underrun_d = 1'b1;
            if (phase_q == PH_LAST && sym_cnt_q == SYM_LAST) state_d = S_FLUSH;
          end else if (tick) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
            if (flush_cnt_q == FL_LAST) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_o  = !abort_i;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    bits_ready_o  = slot;
    sym_load_o    = slot & bits_valid_i;
    sample_en_o   = tick;
    zero_insert_o = tick & !(slot & bits_valid_i);

    pipe_d[0] = tick;
    for (int i = 1; i < PIPE_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  assign out_valid_o = pipe_q[PIPE_LAT-1];
  assign busy_o      = (state_q != S_IDLE) || (|pipe_q);
  assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_qam_tx_sequencer.sv
// Bench for qam_tx_sequencer: frame-timeline model checked every cycle on two instances (CLK_DIV 2 and 1).
module tb_qam_tx_sequencer;
  localparam int SPS = 4;
  localparam int FS  = 4;
  localparam int FL  = 8;
  localparam int P   = 3;
  localparam int NT  = FS * SPS + FL;

  typedef struct packed {logic br, sl, se, zi, ov, busy, done, un;} out_t;
  typedef struct packed {logic act; int t; logic unr; logic [P-1:0] hist;} mst_t;

  logic clk = 1'b0;
  logic rst_n, start0, abort0, bv0, start1, abort1, bv1;
  logic br0, sl0, se0, zi0, ov0, busy0, done0, un0;
  logic br1, sl1, se1, zi1, ov1, busy1, done1, un1;

  int checks = 0, errors = 0, cyc = 0, t0 = 0, ov_mark = 0;
  int c_se[2], c_sl[2], c_zi[2], c_ov[2], c_done[2], first_se[2], first_done[2], last_done[2];
  mst_t ms[2];
  out_t act_o, exp_o;
  mst_t nms;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qam_tx_sequencer #(.SPS(SPS), .FRAME_SYMS(FS), .FLUSH_SAMPLES(FL), .CLK_DIV(2), .PIPE_LAT(P)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .abort_i(abort0), .bits_valid_i(bv0),
    .bits_ready_o(br0), .sym_load_o(sl0), .sample_en_o(se0), .zero_insert_o(zi0),
    .out_valid_o(ov0), .busy_o(busy0), .done_o(done0), .underrun_o(un0));

  qam_tx_sequencer #(.SPS(SPS), .FRAME_SYMS(FS), .FLUSH_SAMPLES(FL), .CLK_DIV(1), .PIPE_LAT(P)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .abort_i(abort1), .bits_valid_i(bv1),
    .bits_ready_o(br1), .sym_load_o(sl1), .sample_en_o(se1), .zero_insert_o(zi1),
    .out_valid_o(ov1), .busy_o(busy1), .done_o(done1), .underrun_o(un1));

  // Frame as a timeline: t counts cycles since the IDLE cycle that saw start.
  function automatic void model_step(input mst_t s, input int cd, input logic rn, input logic st,
                                     input logic ab, input logic bv, output out_t e, output mst_t ns);
    logic tick, slot;
    int k;
    e = '0; ns = s; tick = 1'b0; slot = 1'b0;
    if (!rn) begin
      ns = '0;
    end else begin
      e.un = s.unr;
      if (s.act) begin
        e.busy = 1'b1;
        if (ab) begin
          ns.act = 1'b0;
        end else begin
          tick = (s.t <= NT * cd) && (s.t % cd == 0);
          k    = s.t / cd - 1;
          slot = tick && (k < FS * SPS) && (k % SPS == 0);
          e.br = slot; e.sl = slot && bv; e.se = tick; e.zi = tick && !(slot && bv);
          if (slot && !bv) ns.unr = 1'b1;
          if (s.t == NT * cd + 1) begin
            e.done = 1'b1;
            ns.act = 1'b0;
          end else begin
            ns.t = s.t + 1;
          end
        end
      end else begin
        e.busy = (s.hist != '0);
        if (st) begin
          ns.act = 1'b1; ns.t = 1; ns.unr = 1'b0;
        end
      end
      e.ov    = s.hist[P-1];
      ns.hist = {s.hist[P-2:0], tick};
    end
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    for (int m = 0; m < 2; m++) begin
      c_se[m] = 0; c_sl[m] = 0; c_zi[m] = 0; c_ov[m] = 0; c_done[m] = 0;
      first_se[m] = -1; first_done[m] = -1; last_done[m] = -1;
    end
  endtask

  initial begin
    ms[0] = '0; ms[1] = '0;
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (m == 0) begin
          act_o = {br0, sl0, se0, zi0, ov0, busy0, done0, un0};
          model_step(ms[0], 2, rst_n, start0, abort0, bv0, exp_o, nms);
        end else begin
          act_o = {br1, sl1, se1, zi1, ov1, busy1, done1, un1};
          model_step(ms[1], 1, rst_n, start1, abort1, bv1, exp_o, nms);
        end
        checks++;
        if (act_o !== exp_o) begin
          errors++;
          $display("FAIL dut%0d outputs cycle %0d got br/sl/se/zi/ov/busy/done/un=%b want=%b",
                   m, cyc, act_o, exp_o);
        end
        ms[m] = nms;
        if (act_o.se) begin
          c_se[m]++;
          if (first_se[m] < 0) first_se[m] = cyc;
        end
        if (act_o.sl) c_sl[m]++;
        if (act_o.zi) c_zi[m]++;
        if (act_o.ov) c_ov[m]++;
        if (act_o.done) begin
          c_done[m]++;
          if (first_done[m] < 0) first_done[m] = cyc;
          last_done[m] = cyc;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start0 = 1'b0; abort0 = 1'b0; bv0 = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; bv1 = 1'b1;
    clear_stats();
    step(3);
    check("reset busy", int'(busy0), 0);
    check("reset out_valid", int'(ov0), 0);
    check("reset underrun", int'(un0), 0);
    rst_n = 1'b1;
    step(2);

    // single frame, source always ready
    clear_stats(); start0 = 1'b1; t0 = cyc; step(1); start0 = 1'b0; step(60);
    check("f1 sample_en count", c_se[0], 24);
    check("f1 sym_load count", c_sl[0], 4);
    check("f1 zero_insert count", c_zi[0], 20);
    check("f1 out_valid count", c_ov[0], 24);
    check("f1 first tick offset", first_se[0] - t0, 2);
    check("f1 done offset", first_done[0] - t0, 49);
    check("f1 done count", c_done[0], 1);
    check("f1 underrun", int'(un0), 0);

    // third symbol slot missed
    clear_stats(); start0 = 1'b1; t0 = cyc; step(1); start0 = 1'b0;
    step(11); bv0 = 1'b0; step(10); bv0 = 1'b1; step(39);
    check("f2 sym_load count", c_sl[0], 3);
    check("f2 zero_insert count", c_zi[0], 21);
    check("f2 done offset", first_done[0] - t0, 49);
    check("f2 underrun sticky", int'(un0), 1);

    // start held: back-to-back frames
    clear_stats(); start0 = 1'b1; t0 = cyc; step(2);
    check("f3 underrun cleared", int'(un0), 0);
    step(48);
    check("f3 busy at boundary", int'(busy0), 1);
    step(20); start0 = 1'b0; step(45);
    check("f3 done count", c_done[0], 2);
    check("f3 done offset", first_done[0] - t0, 49);
    check("f3 frame spacing", last_done[0] - first_done[0], 50);
    check("f3 sample_en count", c_se[0], 48);
    check("f3 sym_load count", c_sl[0], 8);

    // abort on the 10th tick
    clear_stats(); start0 = 1'b1; t0 = cyc; step(1); start0 = 1'b0; step(19);
    abort0 = 1'b1; ov_mark = c_ov[0]; step(1); abort0 = 1'b0;
    for (int i = 0; i < 10 && busy0; i++) step(1);
    check("abort drained busy", int'(busy0), 0);
    step(30);
    check("abort sample_en count", c_se[0], 9);
    check("abort no done", c_done[0], 0);
    check("abort residual out_valid", int'((c_ov[0] - ov_mark) <= P), 1);
    check("abort out_valid count", c_ov[0], 9);

    // reset during flush, then restart
    clear_stats(); start0 = 1'b1; t0 = cyc; step(1); start0 = 1'b0; step(40);
    rst_n = 1'b0; #1;
    check("rst out_valid zero", int'(ov0), 0);
    check("rst busy zero", int'(busy0), 0);
    check("rst sample_en zero", int'(se0), 0);
    step(1); clear_stats(); rst_n = 1'b1; start0 = 1'b1; t0 = cyc; step(1); start0 = 1'b0; step(60);
    check("restart first tick", first_se[0] - t0, 2);
    check("restart done offset", first_done[0] - t0, 49);
    check("restart sample_en count", c_se[0], 24);

    // CLK_DIV = 1 instance
    clear_stats(); start1 = 1'b1; t0 = cyc; step(1); start1 = 1'b0; step(35);
    check("div1 sample_en count", c_se[1], 24);
    check("div1 first tick", first_se[1] - t0, 1);
    check("div1 contiguous ticks", first_done[1] - first_se[1], 24);
    check("div1 done offset", first_done[1] - t0, 25);
    check("div1 out_valid count", c_ov[1], 24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
